// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes in_a - in_b - in_c one bit per clock, LSB first,
// using a single full-subtractor cell and one borrow flop behind valid/ready handshakes.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_c,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_s,
   output logic             out_c,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             bw;
   logic [CW-1:0]    cnt;

   logic a_i, b_i, d_i, bw_next;
   logic [WIDTH-1:0] res_next;

   // Full-subtractor cell on the current LSBs of the operand registers.
   assign a_i      = a_sr[0];
   assign b_i      = b_sr[0];
   assign d_i      = a_i ^ b_i ^ bw;
   assign bw_next  = (~a_i & b_i) | (~(a_i ^ b_i) & bw);
   assign res_next = {d_i, res_sr[WIDTH-1:1]};

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order in this block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_s     <= '0;
         out_c     <= 1'b0;
         a_sr      <= '0;
         b_sr      <= '0;
         res_sr    <= '0;
         bw        <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               if (in_valid && in_ready) begin
                  a_sr     <= in_a;
                  b_sr     <= in_b;
                  bw       <= in_c;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= res_next;
               bw     <= bw_next;
               cnt    <= cnt + 1'b1;
               // Last bit: publish the difference straight from the cell so the
               // result is valid WIDTH edges after acceptance.
               if (cnt == CW'(WIDTH - 1)) begin
                  out_s     <= res_next;
                  out_c     <= bw_next;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed table, backpressure and
// mid-operation reset sequences, plus random operands at WIDTH=4 and WIDTH=8.
module tb_serial_subtractor;

   logic clk;
   logic rst_n;

   logic [3:0] a4, b4, s4;
   logic       c4, iv4, ir4, co4, ov4, or4;
   logic [7:0] a8, b8, s8;
   logic       c8, iv8, ir8, co8, ov8, or8;

   int errors = 0;
   int checks = 0;

   serial_subtractor #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_a(a4), .in_b(b4), .in_c(c4),
      .in_valid(iv4), .in_ready(ir4), .out_s(s4), .out_c(co4),
      .out_valid(ov4), .out_ready(or4)
   );

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_a(a8), .in_b(b8), .in_c(c8),
      .in_valid(iv8), .in_ready(ir8), .out_s(s8), .out_c(co8),
      .out_valid(ov8), .out_ready(or8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // One WIDTH=4 operation; returns result and number of edges to out_valid.
   task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic c,
                       output logic [3:0] s, output logic co, output int lat);
      int guard = 0;
      while (!ir4 && guard < 40) begin
         @(posedge clk); #1; guard++;
      end
      if (!ir4) check("w4 in_ready timeout", 32'(ir4), 32'd1);
      a4 = a; b4 = b; c4 = c; iv4 = 1'b1;
      @(posedge clk); #1;
      iv4 = 1'b0;
      a4 = ~a; b4 = ~b; c4 = ~c;   // must not affect the running operation
      lat = 0;
      while (!ov4 && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      s = s4; co = co4;
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       output logic [7:0] s, output logic co, output int lat);
      int guard = 0;
      while (!ir8 && guard < 40) begin
         @(posedge clk); #1; guard++;
      end
      if (!ir8) check("w8 in_ready timeout", 32'(ir8), 32'd1);
      a8 = a; b8 = b; c8 = c; iv8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0;
      a8 = ~a; b8 = ~b; c8 = ~c;
      lat = 0;
      while (!ov8 && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      s = s8; co = co8;
   endtask

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       c;
      logic [3:0] s;
      logic       co;
   } vec_t;

   vec_t vecs[10];

   initial begin
      logic [3:0] s;
      logic [7:0] s_w;
      logic       co;
      int         lat;
      int         guard;
      logic [4:0] exp5;
      logic [8:0] exp9;

      vecs[0] = '{4'd9,  4'd3,  1'b0, 4'h6, 1'b0};
      vecs[1] = '{4'd3,  4'd9,  1'b0, 4'hA, 1'b1};
      vecs[2] = '{4'd0,  4'd0,  1'b1, 4'hF, 1'b1};
      vecs[3] = '{4'd15, 4'd15, 1'b1, 4'hF, 1'b1};
      vecs[4] = '{4'd12, 4'd5,  1'b0, 4'h7, 1'b0};
      vecs[5] = '{4'd5,  4'd5,  1'b0, 4'h0, 1'b0};
      vecs[6] = '{4'd7,  4'd0,  1'b1, 4'h6, 1'b0};
      vecs[7] = '{4'd0,  4'd15, 1'b0, 4'h1, 1'b1};
      vecs[8] = '{4'd15, 4'd0,  1'b0, 4'hF, 1'b0};
      vecs[9] = '{4'd8,  4'd1,  1'b1, 4'h6, 1'b0};

      a4 = '0; b4 = '0; c4 = 1'b0; iv4 = 1'b0; or4 = 1'b1;
      a8 = '0; b8 = '0; c8 = 1'b0; iv8 = 1'b0; or8 = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset in_ready",  32'(ir4), 32'd0);
      check("reset out_valid", 32'(ov4), 32'd0);
      check("reset out_s",     32'(s4),  32'd0);
      check("reset out_c",     32'(co4), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("in_ready after reset", 32'(ir4), 32'd1);

      // Directed table
      for (int i = 0; i < 10; i++) begin
         run4(vecs[i].a, vecs[i].b, vecs[i].c, s, co, lat);
         check($sformatf("vec%0d latency", i), 32'(lat), 32'd4);
         check($sformatf("vec%0d out_s", i),   32'(s),   32'(vecs[i].s));
         check($sformatf("vec%0d out_c", i),   32'(co),  32'(vecs[i].co));
         check($sformatf("vec%0d in_ready in DONE", i), 32'(ir4), 32'd0);
         @(posedge clk); #1;
         check($sformatf("vec%0d out_valid drop", i), 32'(ov4), 32'd0);
         check($sformatf("vec%0d in_ready back", i),  32'(ir4), 32'd1);
         check($sformatf("vec%0d out_s held", i),     32'(s4),  32'(vecs[i].s));
      end

      // Backpressure: result held for 6 cycles, in_valid pulses ignored
      or4 = 1'b0;
      run4(4'd12, 4'd5, 1'b0, s, co, lat);
      check("bp latency", 32'(lat), 32'd4);
      for (int i = 0; i < 6; i++) begin
         a4 = 4'(i); b4 = 4'd1; c4 = 1'b1; iv4 = i[0];
         @(posedge clk); #1;
         check("bp out_valid", 32'(ov4), 32'd1);
         check("bp out_s",     32'(s4),  32'd7);
         check("bp out_c",     32'(co4), 32'd0);
         check("bp in_ready",  32'(ir4), 32'd0);
      end
      iv4 = 1'b0;
      or4 = 1'b1;
      @(posedge clk); #1;
      check("bp release out_valid", 32'(ov4), 32'd0);
      check("bp release in_ready",  32'(ir4), 32'd1);

      // Reset two cycles into RUN
      a4 = 4'd8; b4 = 4'd1; c4 = 1'b0; iv4 = 1'b1;
      @(posedge clk); #1;
      iv4 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst in_ready",  32'(ir4), 32'd0);
      check("midrst out_valid", 32'(ov4), 32'd0);
      check("midrst out_s",     32'(s4),  32'd0);
      check("midrst out_c",     32'(co4), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("midrst in_ready after", 32'(ir4), 32'd1);
      guard = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (ov4) guard++;
      end
      check("midrst no stale out_valid", 32'(guard), 32'd0);

      // Random WIDTH=4
      for (int i = 0; i < 1000; i++) begin
         logic [3:0] ra, rb;
         logic       rc;
         ra = 4'($urandom); rb = 4'($urandom); rc = 1'($urandom);
         exp5 = {1'b0, ra} - {1'b0, rb} - {4'b0, rc};
         run4(ra, rb, rc, s, co, lat);
         check($sformatf("w4 rnd%0d lat", i), 32'(lat), 32'd4);
         check($sformatf("w4 rnd%0d a=%0h b=%0h c=%0b", i, ra, rb, rc),
               32'({co, s}), 32'(exp5));
      end

      // Random WIDTH=8
      for (int i = 0; i < 1000; i++) begin
         logic [7:0] ra, rb;
         logic       rc;
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         if (i == 0) begin ra = 8'h00; rb = 8'hFF; rc = 1'b1; end
         exp9 = {1'b0, ra} - {1'b0, rb} - {8'b0, rc};
         run8(ra, rb, rc, s_w, co, lat);
         check($sformatf("w8 rnd%0d lat", i), 32'(lat), 32'd8);
         check($sformatf("w8 rnd%0d a=%0h b=%0h c=%0b", i, ra, rb, rc),
               32'({co, s_w}), 32'(exp9));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
